// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// burst FSM state type and the mode-mapping helper.
// Optional rotate modes are enabled by defining UNIV_SHIFT_REG_ROTATE_EN.
package usr_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;  // shift right
    localparam logic [1:0] MODE_SL = 2'b01;  // shift left
    localparam logic [1:0] MODE_RR = 2'b10;  // rotate right
    localparam logic [1:0] MODE_RL = 2'b11;  // rotate left

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } usr_state_e;

    // Maps a requested mode onto the mode the datapath actually executes.
    // Without rotate support, rotate requests fall back to the plain shift
    // in the same direction, so bit 1 is forced low.
    function automatic logic [1:0] map_mode(input logic [1:0] m);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        return m;
`else
        return m & 2'b01;
`endif
    endfunction

    // Bit 0 of the executed mode selects the left direction.
    function automatic logic is_left(input logic [1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Debug/observation bundle for the universal shift register: exposes the
// burst FSM state, remaining step count and the mode currently in effect.
interface univ_shift_reg_if #(
    parameter int CNT_W = 4
);
    import usr_pkg::*;

    usr_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_eff;

    // src: driven by the register; mon: read-only observer.
    modport src (output state, output cnt, output mode_eff);
    modport mon (input state, input cnt, input mode_eff);
endinterface

// File: rtl/univ_shift_reg_ctrl.sv
// Burst controller for univ_shift_reg: IDLE/SHIFT/DONE FSM, step counter
// and the mode latched at burst start.
// Handshake: a burst is accepted only in IDLE when start is high and L is
// low; busy is high for exactly n cycles (one step each), then done pulses
// for one cycle with busy low, then the FSM returns to IDLE.
module usr_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             L,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             step,
    output logic [1:0]       mode_lat,
    output usr_state_e       state,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    usr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    // State, counter and latched-mode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_SR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state, counter update and status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy    = 1'b0;
        done    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A load request outranks a burst request in the same cycle.
                if (!L && start) begin
                    if (n != '0) begin
                        state_d = ST_SHIFT;
                        cnt_d   = n;
                        mode_d  = map_mode(mode);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                step  = 1'b1;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mode_lat = mode_q;
    assign state    = state_q;
    assign cnt      = cnt_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single-step shift and
// counted burst shifting. Rotate modes exist only when
// UNIV_SHIFT_REG_ROTATE_EN is defined; otherwise rotate requests act as
// shifts in the same direction.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             L,
    input  logic             Sh,
    input  logic [1:0]       mode,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             busy,
    output logic             done,
    univ_shift_reg_if.src    dbg
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             step;
    logic [1:0]       mode_lat;
    logic [1:0]       mode_eff;
    usr_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             idle;
    logic             do_load;
    logic             do_step;

    usr_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .L        (L),
        .start    (start),
        .n        (n),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .step     (step),
        .mode_lat (mode_lat),
        .state    (state),
        .cnt      (cnt)
    );

    // Request decode: in IDLE, L beats start beats Sh; a burst owns the
    // datapath while it runs and uses the mode captured at its start.
    always_comb begin
        idle     = (state == ST_IDLE);
        mode_eff = busy ? mode_lat : map_mode(mode);
        do_load  = idle && L;
        do_step  = step || (idle && !L && !start && Sh);
    end

    // Datapath next value: load, one shift/rotate step, or hold.
    always_comb begin
        q_d = q_q;
        if (do_load) begin
            q_d = D;
        end else if (do_step) begin
            case (mode_eff)
                MODE_SL: q_d = {q_q[WIDTH-2:0], SI};
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                MODE_RR: q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_RL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`endif
                default: q_d = {SI, q_q[WIDTH-1:1]};
            endcase
        end
    end

    // Register contents with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign SO = is_left(mode_eff) ? q_q[WIDTH-1] : q_q[0];

    assign dbg.state    = state;
    assign dbg.cnt      = cnt;
    assign dbg.mode_eff = mode_eff;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: a vector table of
// single-cycle load/shift operations plus hand-written burst sequences.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             L;
  logic             Sh;
  logic [1:0]       mode;
  logic             SI;
  logic [WIDTH-1:0] D;
  logic             start;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             busy;
  logic             done;

  univ_shift_reg_if #(.CNT_W(CNT_W)) dbg_if ();

  univ_shift_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .L     (L),
    .Sh    (Sh),
    .mode  (mode),
    .SI    (SI),
    .D     (D),
    .start (start),
    .n     (n),
    .Q     (Q),
    .SO    (SO),
    .busy  (busy),
    .done  (done),
    .dbg   (dbg_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic             rst;
    logic             l;
    logic             sh;
    logic [1:0]       mode;
    logic             si;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_q;
    logic             exp_so;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; L = 1'b0; Sh = 1'b0; mode = 2'b00; SI = 1'b0;
    D = '0; start = 1'b0; n = '0;
  endtask

  logic [WIDTH-1:0] exp_s1, exp_s2, exp_s3;
  int busy_cnt;
  int done_cnt;

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();

    // rst, L, Sh, mode, SI, D, expected Q, expected SO
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b1011, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b1101, 4'b1101, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0000, 4'b0110, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 4'b1010, 4'b1010, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'b0011, 4'b0011, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 4'b0000, 4'b0111, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 4'b0000, 4'b1111, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0101, 4'b1111, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'b0000, 4'b1111, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b0000, 4'b0111, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 4'b0000, 4'b1110, 1'b1};

    // table: single-cycle load / shift / hold
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; L = vecs[i].l; Sh = vecs[i].sh; mode = vecs[i].mode;
      SI = vecs[i].si; D = vecs[i].d; start = 1'b0; n = '0;
      tick();
      chk($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d_so", i), 32'(SO), 32'(vecs[i].exp_so));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_done", i), 32'(done), 32'd0);
    end
    chk("reset_state_after_table", 32'(dbg_if.state), 32'(ST_IDLE));

    // burst n=3, mode=10 from Q=1001, L ignored while busy
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    exp_s1 = 4'b1100; exp_s2 = 4'b0110; exp_s3 = 4'b0011;
`else
    exp_s1 = 4'b0100; exp_s2 = 4'b0010; exp_s3 = 4'b0001;
`endif
    idle_inputs();
    L = 1'b1; D = 4'b1001;
    tick();
    chk("b3_load", 32'(Q), 32'h9);
    idle_inputs();
    start = 1'b1; n = 4'd3; mode = 2'b10; SI = 1'b0;
    tick();
    chk("b3_accept_busy", 32'(busy), 32'd1);
    chk("b3_accept_q", 32'(Q), 32'h9);
    chk("b3_accept_cnt", 32'(dbg_if.cnt), 32'd3);
    // disturb every request input while busy
    start = 1'b1; n = 4'd1; L = 1'b1; D = 4'b1111; Sh = 1'b1; mode = 2'b01;
    tick();
    chk("b3_s1_q", 32'(Q), 32'(exp_s1));
    chk("b3_s1_busy", 32'(busy), 32'd1);
    chk("b3_s1_so_latched", 32'(SO), 32'(exp_s1[0]));
    tick();
    chk("b3_s2_q", 32'(Q), 32'(exp_s2));
    chk("b3_s2_busy", 32'(busy), 32'd1);
    tick();
    chk("b3_s3_q", 32'(Q), 32'(exp_s3));
    chk("b3_done_pulse", 32'(done), 32'd1);
    chk("b3_done_busy", 32'(busy), 32'd0);
    idle_inputs();
    tick();
    chk("b3_after_done", 32'(done), 32'd0);
    chk("b3_after_q", 32'(Q), 32'(exp_s3));
    chk("b3_after_state", 32'(dbg_if.state), 32'(ST_IDLE));

    // start with n=0: immediate done, never busy
    start = 1'b1; n = 4'd0; mode = 2'b01; SI = 1'b1;
    tick();
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_q", 32'(Q), 32'(exp_s3));
    idle_inputs();
    tick();
    chk("n0_done_clear", 32'(done), 32'd0);
    chk("n0_busy_idle", 32'(busy), 32'd0);

    // burst n=5 mode=11 aborted by reset
    L = 1'b1; D = 4'b0110;
    tick();
    idle_inputs();
    start = 1'b1; n = 4'd5; mode = 2'b11;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_q", 32'(Q), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_state", 32'(dbg_if.state), 32'(ST_IDLE));
    chk("abort_cnt", 32'(dbg_if.cnt), 32'd0);
    done_cnt = 0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // mode=10 single step with SI=1 on 0001 gives 1000 in both builds
    L = 1'b1; D = 4'b0001;
    tick();
    idle_inputs();
    Sh = 1'b1; mode = 2'b10; SI = 1'b1;
    tick();
    chk("m10_step_q", 32'(Q), 32'h8);
    chk("m10_step_so", 32'(SO), 32'd0);

    // burst n=6 >= WIDTH, shift right filling with SI=1 from 1010
    idle_inputs();
    L = 1'b1; D = 4'b1010;
    tick();
    idle_inputs();
    start = 1'b1; n = 4'd6; mode = 2'b00; SI = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      if (busy) busy_cnt++;
      tick();
      if (done) done_cnt++;
    end
    chk("b6_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("b6_done_seen", 32'(done_cnt), 32'd1);
    chk("b6_q", 32'(Q), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
